// File: rtl/econet_coldet.sv
// -----------------------------------------------------------------------------
// econet_coldet
//   Conditions the raw Econet collision-detect comparator output into a
//   filtered level, a one-cycle rising-edge event, a sticky status bit with
//   interrupt enable, and a saturating collision event counter. All state is
//   visible through a single 32-bit memory-mapped register.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high reset
//   wr[3:0]          byte write strobes; wr[n] covers data_in[8n+7:8n]
//   select           register select
//   data_in[31:0]    write data
//   data_out[31:0]   read data: {count, 12'b0, sync, filtered, status, ie}
//   collision_detect raw asynchronous collision comparator output
//   coldet_active    filtered collision level
//   coldet_interrupt level interrupt request (status & ie)
// -----------------------------------------------------------------------------
module econet_coldet #(
    parameter int FILTER_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  wr,
    input  logic        select,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        collision_detect,
    output logic        coldet_active,
    output logic        coldet_interrupt
);

    localparam logic [7:0]       FC_LAST  = 8'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_r;
    logic             sync2_r;
    logic             filtered_r;
    logic             filtered_d_r;
    logic [7:0]       fc_r;
    logic             ie_r;
    logic             status_r;
    logic [CNT_W-1:0] count_r;

    logic             wr_en_s;
    logic             ie_wr_s;
    logic             status_clr_s;
    logic             cnt_clr_s;
    logic             event_s;
    logic             filt_nxt_s;
    logic [7:0]       fc_nxt_s;
    logic             ie_nxt_s;
    logic             status_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [15:0]      cnt_ext_s;

    // Write data bits that only drive read-only fields are deliberately ignored.
    logic unused_data_s;
    assign unused_data_s = ^{data_in[31:17], data_in[15:2]};

    // Register write decode and rising-edge event of the filtered level.
    always_comb begin
        wr_en_s      = select & (wr != 4'b0000);
        ie_wr_s      = wr_en_s & wr[0];
        status_clr_s = ie_wr_s & data_in[1];
        cnt_clr_s    = wr_en_s & wr[2] & data_in[16];
        event_s      = filtered_r & ~filtered_d_r;
    end

    // Glitch filter: flip only after FILTER_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_nxt_s = filtered_r;
        fc_nxt_s   = 8'd0;
        if (sync2_r == filtered_r) begin
            filt_nxt_s = filtered_r;
            fc_nxt_s   = 8'd0;
        end else if (fc_r == FC_LAST) begin
            filt_nxt_s = sync2_r;
            fc_nxt_s   = 8'd0;
        end else begin
            filt_nxt_s = filtered_r;
            fc_nxt_s   = fc_r + 8'd1;
        end
    end

    // Status/IE/counter next state; a coincident event beats any clear.
    always_comb begin
        status_nxt_s = status_r;
        ie_nxt_s     = ie_r;
        count_nxt_s  = count_r;
        if (event_s) begin
            status_nxt_s = 1'b1;
        end else if (status_clr_s) begin
            status_nxt_s = 1'b0;
        end else begin
            status_nxt_s = status_r;
        end
        if (ie_wr_s) begin
            ie_nxt_s = data_in[0];
        end else begin
            ie_nxt_s = ie_r;
        end
        if (cnt_clr_s) begin
            count_nxt_s = event_s ? CNT_ONE : CNT_ZERO;
        end else if (event_s && (count_r != CNT_MAX)) begin
            count_nxt_s = count_r + CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Synchroniser, filter state and edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            filtered_r   <= 1'b0;
            filtered_d_r <= 1'b0;
            fc_r         <= 8'd0;
        end else begin
            sync1_r      <= collision_detect;
            sync2_r      <= sync1_r;
            filtered_r   <= filt_nxt_s;
            filtered_d_r <= filtered_r;
            fc_r         <= fc_nxt_s;
        end
    end

    // Software-visible control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_r     <= 1'b0;
            status_r <= 1'b0;
            count_r  <= CNT_ZERO;
        end else begin
            ie_r     <= ie_nxt_s;
            status_r <= status_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Zero-extend the counter into the 16-bit count field.
    always_comb begin
        cnt_ext_s               = 16'h0000;
        cnt_ext_s[CNT_W-1:0]    = count_r;
    end

    assign data_out         = {cnt_ext_s, 12'h000, sync2_r, filtered_r, status_r, ie_r};
    assign coldet_active    = filtered_r;
    assign coldet_interrupt = status_r & ie_r;

endmodule

// File: tb/tb_econet_coldet.sv
// -----------------------------------------------------------------------------
// tb_econet_coldet
//   Drives two instances (16-bit and 4-bit counters) from the same stimulus
//   and compares them every cycle against a behavioural model, plus directed
//   checks on the key scenarios.
// -----------------------------------------------------------------------------
module tb_econet_coldet;

    localparam int FC = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  wr = 4'b0000;
    logic        select = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        collision_detect = 1'b0;
    logic [31:0] dout16, dout4;
    logic        act16, act4, irq16, irq4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    econet_coldet #(.FILTER_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .wr(wr), .select(select), .data_in(data_in),
        .data_out(dout16), .collision_detect(collision_detect),
        .coldet_active(act16), .coldet_interrupt(irq16)
    );

    econet_coldet #(.FILTER_CYCLES(FC), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .wr(wr), .select(select), .data_in(data_in),
        .data_out(dout4), .collision_detect(collision_detect),
        .coldet_active(act4), .coldet_interrupt(irq4)
    );

    // ---------------- behavioural model ----------------
    bit m_raw[$];   // raw input as seen through the two-stage delay line
    bit m_s2h[$];   // recent synchronised samples since the last level change
    bit m_filt, m_filt_prev, m_ie, m_st;
    int m_cnt16, m_cnt4;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_raw = {1'b0, 1'b0};
        m_s2h.delete();
        m_filt = 1'b0; m_filt_prev = 1'b0; m_ie = 1'b0; m_st = 1'b0;
        m_cnt16 = 0; m_cnt4 = 0;
    endtask

    task automatic model_edge();
        bit s2, ev, we, all_differ;
        if (reset) begin
            model_reset();
            return;
        end
        s2 = m_raw[0];
        ev = m_filt && !m_filt_prev;
        we = select && (wr != 4'b0000);
        if (ev) m_st = 1'b1;
        else if (we && wr[0] && data_in[1]) m_st = 1'b0;
        if (we && wr[0]) m_ie = data_in[0];
        if (we && wr[2] && data_in[16]) begin
            m_cnt16 = ev ? 1 : 0;
            m_cnt4  = ev ? 1 : 0;
        end else if (ev) begin
            m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
            m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
        end
        m_filt_prev = m_filt;
        // the level changes once the last FC samples all disagree with it
        m_s2h.push_back(s2);
        while (m_s2h.size() > FC) void'(m_s2h.pop_front());
        if (m_s2h.size() == FC) begin
            all_differ = 1'b1;
            foreach (m_s2h[i]) if (m_s2h[i] == m_filt) all_differ = 1'b0;
            if (all_differ) begin
                m_filt = s2;
                m_s2h.delete();
            end
        end
        m_raw.push_back(collision_detect);
        void'(m_raw.pop_front());
    endtask

    task automatic check_all();
        logic [31:0] e16, e4;
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = m_cnt16[15:0];
        c4  = m_cnt4[3:0];
        e16 = {c16, 12'h000, m_raw[0], m_filt, m_st, m_ie};
        e4  = {12'h000, c4, 12'h000, m_raw[0], m_filt, m_st, m_ie};
        check("data_out_w16", dout16, e16);
        check("data_out_w4", dout4, e4);
        check("active_w16", {31'h0, act16}, {31'h0, m_filt});
        check("active_w4", {31'h0, act4}, {31'h0, m_filt});
        check("irq_w16", {31'h0, irq16}, {31'h0, m_st & m_ie});
        check("irq_w4", {31'h0, irq4}, {31'h0, m_st & m_ie});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reg_write(logic [31:0] d, logic [3:0] strobes);
        select  = 1'b1;
        wr      = strobes;
        data_in = d;
        step();
        select  = 1'b0;
        wr      = 4'b0000;
        data_in = 32'h0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(int high_cycles);
        collision_detect = 1'b1;
        idle(high_cycles);
        collision_detect = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen_active;
        int hold;

        model_reset();
        idle(3);
        check("reset_dout", dout16, 32'h0000_0000);
        check("reset_irq", {31'h0, irq16}, 32'h0);
        check("reset_active", {31'h0, act16}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Basic collision with interrupts enabled
        reg_write(32'h0000_0001, 4'b0001);
        collision_detect = 1'b1;
        for (int e = 0; e < 30; e++) begin
            step();
            if (e == 16) check("active_before_edge17", {31'h0, act16}, 32'h0);
            if (e == 17) check("active_after_edge17", {31'h0, act16}, 32'h1);
            if (e == 17) check("irq_before_edge18", {31'h0, irq16}, 32'h0);
            if (e == 18) check("irq_after_edge18", {31'h0, irq16}, 32'h1);
            if (e == 18) check("dout_collision", dout16, 32'h0001_000F);
        end
        collision_detect = 1'b0;
        idle(40);

        // Clear status, counter and IE, then glitch rejection
        reg_write(32'h0001_0002, 4'b0101);
        seen_active = 1'b0;
        collision_detect = 1'b1;
        for (int i = 0; i < 10; i++) begin step(); seen_active |= act16; end
        collision_detect = 1'b0;
        step(); seen_active |= act16;
        collision_detect = 1'b1;
        for (int i = 0; i < 15; i++) begin step(); seen_active |= act16; end
        collision_detect = 1'b0;
        for (int i = 0; i < 40; i++) begin step(); seen_active |= act16; end
        check("glitch_no_active", {31'h0, seen_active}, 32'h0);
        check("glitch_dout", dout16, 32'h0000_0000);

        // Masked collision, then enable, then W1C
        pulse(20);
        idle(40);
        check("masked_status", {31'h0, dout16[1]}, 32'h1);
        check("masked_irq", {31'h0, irq16}, 32'h0);
        reg_write(32'h0000_0001, 4'b0001);
        check("unmask_irq", {31'h0, irq16}, 32'h1);
        reg_write(32'h0000_0002, 4'b0001);
        check("w1c_status_ie", {30'h0, dout16[1:0]}, 32'h0);
        check("w1c_irq", {31'h0, irq16}, 32'h0);

        // Coincident clears and event
        collision_detect = 1'b1;
        idle(18);
        check("coinc_pre_active", {31'h0, act16}, 32'h1);
        reg_write(32'h0001_0002, 4'b0101);
        check("coinc_status", {31'h0, dout16[1]}, 32'h1);
        check("coinc_count16", {16'h0, dout16[31:16]}, 32'h1);
        check("coinc_count4", {16'h0, dout4[31:16]}, 32'h1);
        collision_detect = 1'b0;
        idle(40);

        // Saturation of the 4-bit counter
        for (int n = 0; n < 20; n++) begin
            pulse(20);
            idle(20);
        end
        check("sat_count4", {16'h0, dout4[31:16]}, 32'h0000_000F);
        check("count16_21", {16'h0, dout16[31:16]}, 32'd21);

        // Reset part-way through the filter with input held high
        collision_detect = 1'b1;
        idle(10);
        check("midfilter_inactive", {31'h0, act16}, 32'h0);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("async_reset_dout", dout16, 32'h0000_0000);
        idle(2);
        reset = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (e == 16) check("rst_release_edge16", {31'h0, act16}, 32'h0);
            if (e == 17) check("rst_release_edge17", {31'h0, act16}, 32'h1);
            if (e == 18) check("rst_release_count", {16'h0, dout16[31:16]}, 32'h1);
        end
        collision_detect = 1'b0;
        idle(30);

        // Randomised traffic
        hold = 0;
        for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
                collision_detect = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 40));
            end
            hold--;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                select  = 1'($urandom_range(0, 1));
                wr      = 4'($urandom_range(0, 15));
                data_in = $urandom;
                step();
                select  = 1'b0;
                wr      = 4'b0000;
                data_in = 32'h0;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/econet_coldet.md
Name: econet_coldet

Overview:
- Conditions the raw Econet collision-detect comparator input and turns it into a bus-visible, maskable interrupt source.
- Sits between the collision_detect pin and the CPU interrupt controller, alongside the Econet hardware-control register.
- Provides a 2-FF synchroniser, a consecutive-sample glitch filter, rising-edge event detection, a sticky write-1-to-clear status bit, an interrupt enable and a saturating collision event counter.
- Everything is exposed through one 32-bit memory-mapped register.

Parameters:
- FILTER_CYCLES, 16: consecutive synchronised samples that must disagree with the filtered level before it flips. Legal range 1..255.
- CNT_W, 16: event counter width. Legal range 1..16.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- wr  in  4  byte write strobes; wr[n] covers data_in[8n+7:8n]
- select  in  1  register select
- data_in  in  32  write data
- data_out  out  32  read data, combinational from registers
- collision_detect  in  1  raw asynchronous collision comparator output
- coldet_active  out  1  filtered collision level
- coldet_interrupt  out  1  interrupt request, level, active-high

Behaviour:
- Register layout of data_out:
  - bit0 IE (read/write)
  - bit1 STATUS (sticky)
  - bit2 filtered level
  - bit3 synchronised raw level
  - bits[15:4] zero
  - bits[31:16] event count, zero-extended from CNT_W
- A write takes effect only when select=1 and wr!=0.
- Reset values: sync FFs 0, filtered 0, filter counter 0, IE 0, STATUS 0, count 0. Therefore coldet_active=0 and coldet_interrupt=0.
- Synchroniser: collision_detect passes through two FFs, giving s2.
- Filter:
  - 8-bit counter fc.
  - If s2==filtered, fc is cleared to 0.
  - Otherwise, if fc==FILTER_CYCLES-1, filtered is loaded with s2 and fc is cleared; else fc increments.
  - Net effect: filtered follows s2 after exactly FILTER_CYCLES consecutive mismatching cycles.
  - Any single agreeing sample restarts the count.
- Edge detect: a registered copy filtered_d is kept. event = filtered & ~filtered_d, one cycle wide.
- Latency: raw input high before edge N gives s2 high after edge N+1, filtered high after edge N+1+FILTER_CYCLES, and STATUS/count update after edge N+2+FILTER_CYCLES.
- STATUS:
  - Set on event.
  - Cleared by a write with wr[0]=1 and data_in[1]=1.
  - If event and clear occur in the same cycle, event wins and STATUS stays 1.
- IE: loaded from data_in[0] when wr[0]=1.
- Counter:
  - Increments on event and saturates at all-ones; it never wraps.
  - Cleared by a write with wr[2]=1 and data_in[16]=1.
  - If clear and event occur in the same cycle, the counter becomes 1.
- Read-only bits (2, 3 and 31:16) ignore written data, apart from the clear actions above.
- coldet_interrupt = STATUS & IE, combinational from those registers.
  - Setting IE while STATUS=1 raises the interrupt in the following cycle.
  - Clearing IE drops it without losing STATUS.
- coldet_active = filtered.
- A falling filtered level generates no event.
- Reset asserted mid-filter or mid-event returns all state to the reset values immediately.
  - No event is generated on reset release, even if collision_detect is high then; the full filter delay applies again.

Test Plan:
- Reset, idle input → data_out=0x00000000, coldet_interrupt=0, coldet_active=0.
- FILTER_CYCLES=16, IE=1, collision_detect high for 30 cycles from edge 0:
  - coldet_active rises after edge 17.
  - STATUS=1 and coldet_interrupt=1 after edge 18.
  - count=1; data_out reads 0x0001000F while the input is still high.
- Glitch rejection: high for 10 cycles, low, high for 15, low → no event, count=0, STATUS=0, coldet_active never rises.
- Mask and clear:
  - With IE=0, trigger a collision → STATUS=1, interrupt=0.
  - Write 0x1 with wr=0001 → interrupt=1 next cycle.
  - Write 0x2 with wr=0001 → STATUS=0, IE=0, interrupt=0.
- Coincident W1C and event on the same edge → STATUS remains 1. Coincident counter clear and event → count=1.
- CNT_W=4, 20 separate collisions → count field reads 15 (0x000F0000 in bits 31:16) and holds there.
- Reset mid-filter (fc=8) with input held high → after release, coldet_active rises exactly 17 edges later.
